// File: rtl/clock_gen_bank.sv
// clock_gen_bank: multi-channel clock-enable generator.
// Each channel produces a registered one-cycle tick strobe every D enabled
// cycles and a square wave that toggles on each tick. Divisors are written
// into a shadow register and reach the active register only at the channel's
// terminal count or on restart, so no period is ever cut short.
// Optional feature macro: CLKGEN_CASCADE_EN (channel i>0 counts the ticks of
// channel i-1 instead of clk cycles).
module clock_gen_bank #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 27,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_RST =
    {27'd25_000_000, 27'd50_000_000, 27'd100_000}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              restart,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  output logic              wr_ack,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o
);

  localparam logic [DIV_W-1:0] ZERO     = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE      = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       NUM_CH_L = 4'(NUM_CH);

  logic wr_valid_s;

  // A write is accepted only when it targets an existing channel.
  always_comb begin
    wr_valid_s = 1'b0;
    if (wr_en && ({1'b0, wr_ch} < NUM_CH_L)) begin
      wr_valid_s = 1'b1;
    end else begin
      wr_valid_s = 1'b0;
    end
  end

  // Acknowledge pulse, one cycle after each accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_valid_s;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] shadow_r;
    logic [DIV_W-1:0] active_r;
    logic [DIV_W-1:0] cnt_r;
    logic             tick_r;
    logic             sq_r;
    logic             en_s;
    logic             wr_hit_s;
    logic             term_s;
    logic [DIV_W-1:0] reload_s;

`ifdef CLKGEN_CASCADE_EN
    if (i == 0) begin : g_root
      assign en_s = run;
    end else begin : g_casc
      // Downstream channels advance once per upstream tick.
      assign en_s = run & tick_o[i-1];
    end
`else
    assign en_s = run;
`endif

    // Terminal-count detection and selection of the divisor to reload.
    always_comb begin
      wr_hit_s = 1'b0;
      term_s   = 1'b0;
      reload_s = shadow_r;
      if (wr_valid_s && (wr_ch == 3'(i))) begin
        wr_hit_s = 1'b1;
        reload_s = wr_div;
      end else begin
        wr_hit_s = 1'b0;
        reload_s = shadow_r;
      end
      if (en_s && (active_r != ZERO) && (cnt_r == (active_r - ONE))) begin
        term_s = 1'b1;
      end else begin
        term_s = 1'b0;
      end
    end

    // Shadow/active divisors, counter, tick strobe and square wave.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_r <= DIV_RST[i*DIV_W +: DIV_W];
        active_r <= DIV_RST[i*DIV_W +: DIV_W];
        cnt_r    <= ZERO;
        tick_r   <= 1'b0;
        sq_r     <= 1'b0;
      end else begin
        if (wr_hit_s) begin
          shadow_r <= wr_div;
        end
        if (restart) begin
          cnt_r    <= ZERO;
          sq_r     <= 1'b0;
          active_r <= reload_s;
          tick_r   <= 1'b0;
        end else if (term_s) begin
          cnt_r    <= ZERO;
          sq_r     <= ~sq_r;
          active_r <= reload_s;
          tick_r   <= 1'b1;
        end else if (en_s && (active_r != ZERO)) begin
          cnt_r    <= cnt_r + ONE;
          tick_r   <= 1'b0;
        end else begin
          tick_r   <= 1'b0;
        end
      end
    end

    assign tick_o[i] = tick_r;
    assign sq_o[i]   = sq_r;
  end

endmodule

// File: tb/tb_clock_gen_bank.sv
// Self-checking bench for clock_gen_bank: directed steps followed by a
// randomized phase, every cycle compared against a countdown-based model.
module tb_clock_gen_bank;

  localparam int NCH = 3;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          restart = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_ch = 3'd0;
  logic [DW-1:0] wr_div = 8'd0;
  logic          wr_ack;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] sq_o;

  int tests = 0;
  int fails = 0;

  // Reference model: cycles remaining until the next tick, pending divisor.
  int             m_rem    [NCH];
  int             m_shadow [NCH];
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_sq;
  logic           m_ack;
  int             rst_div  [NCH] = '{2, 3, 4};

  clock_gen_bank #(
    .NUM_CH (NCH),
    .DIV_W  (DW),
    .DIV_RST({8'd4, 8'd3, 8'd2})
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .restart(restart),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .wr_ack (wr_ack),
    .tick_o (tick_o),
    .sq_o   (sq_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_rem[i]    = rst_div[i];
      m_shadow[i] = rst_div[i];
    end
    m_tick = '0;
    m_sq   = '0;
    m_ack  = 1'b0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] prev_tick;
    logic           wr_ok;
    logic           hit;
    logic           en;
    int             newd;
    prev_tick = m_tick;
    wr_ok = wr_en && (int'(wr_ch) < NCH);
    m_ack = wr_ok;
    for (int i = 0; i < NCH; i++) begin
      hit  = wr_ok && (int'(wr_ch) == i);
      newd = hit ? int'(wr_div) : m_shadow[i];
      en   = run;
`ifdef CLKGEN_CASCADE_EN
      if (i > 0) en = run && prev_tick[i-1];
`endif
      m_tick[i] = 1'b0;
      if (restart) begin
        m_rem[i] = newd;
        m_sq[i]  = 1'b0;
      end else if (en && m_rem[i] != 0) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_tick[i] = 1'b1;
          m_sq[i]   = ~m_sq[i];
          m_rem[i]  = newd;
        end
      end
      if (hit) m_shadow[i] = int'(wr_div);
    end
  endtask

  task automatic check(input string tag);
    tests++;
    assert (tick_o === m_tick) else begin
      fails++;
      $error("FAIL %s tick_o got=%b exp=%b t=%0t", tag, tick_o, m_tick, $time);
    end
    tests++;
    assert (sq_o === m_sq) else begin
      fails++;
      $error("FAIL %s sq_o got=%b exp=%b t=%0t", tag, sq_o, m_sq, $time);
    end
    tests++;
    assert (wr_ack === m_ack) else begin
      fails++;
      $error("FAIL %s wr_ack got=%b exp=%b t=%0t", tag, wr_ack, m_ack, $time);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check(tag);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    check("in_reset");
    repeat (n) begin
      @(posedge clk);
      #1;
      check("in_reset");
    end
    rst = 1'b0;
  endtask

  task automatic write(input logic [2:0] ch, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_div = d;
    step("write");
    wr_en = 1'b0;
  endtask

  initial begin
    int c0, c1, c2;
    // Reset and default divisors {4,3,2}
    do_reset(3);
    run = 1'b1;
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < 12; k++) begin
      step("basic");
      c0 += int'(tick_o[0]); c1 += int'(tick_o[1]); c2 += int'(tick_o[2]);
    end
    tests++;
    assert (c0 == 6 && c1 == 4 && c2 == 3) else begin
      fails++;
      $error("FAIL tick_count got=%0d/%0d/%0d exp=6/4/3", c0, c1, c2);
    end

    // Write ch1 divisor 5 mid-period
    step("pre_wr");
    write(3'd1, 8'd5);
    repeat (14) step("div5");

    // Disable ch2, then re-enable with divisor 1 and restart
    write(3'd2, 8'd0);
    repeat (10) step("ch2_off");
    write(3'd2, 8'd1);
    repeat (3) step("ch2_wait");
    restart = 1'b1; step("restart1"); restart = 1'b0;
    c2 = 0;
    for (int k = 0; k < 6; k++) begin
      step("ch2_d1");
      c2 += int'(tick_o[2]);
    end
    tests++;
    assert (c2 == 6) else begin
      fails++;
      $error("FAIL ch2_every_cycle got=%0d exp=6", c2);
    end

    // Freeze for 10 cycles
    run = 1'b0;
    repeat (10) step("freeze");
    run = 1'b1;
    repeat (8) step("resume");

    // Restart, with a simultaneous write
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd3; restart = 1'b1;
    step("restart_wr");
    wr_en = 1'b0; restart = 1'b0;
    repeat (8) step("after_restart");

    // Out-of-range channel write
    write(3'd5, 8'd7);
    repeat (4) step("bad_ch");

    // Randomized phase with one mid-run reset
    for (int k = 0; k < 600; k++) begin
      run     = ($urandom_range(9, 0) != 0);
      restart = ($urandom_range(39, 0) == 0);
      wr_en   = ($urandom_range(7, 0) == 0);
      wr_ch   = 3'($urandom_range(7, 0));
      wr_div  = 8'($urandom_range(6, 0));
      if (k == 300) begin
        wr_en = 1'b0; restart = 1'b0;
        do_reset(2);
      end else begin
        step("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
